// File: rtl/wait_state_mem_pkg.sv
// wait_state_mem_pkg
//   Shared types and helpers for the wait-state memory slave.
//   state_e      : FSM state encoding (IDLE, WAIT, ACCESS, DONE)
//   WAIT_CNT_W   : wait-state counter width (covers 0..255)
//   clog2()      : index / counter width helper
//   byte_lanes() : number of 8-bit lanes in a data word
package wait_state_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int WAIT_CNT_W = 8;

  // Returns at least 1 so a single-word memory still gets a legal index.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result == 0) result = 1;
    return result;
  endfunction

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wait_state_mem_if.sv
// wait_state_mem_if
//   Request/ready bus between the core (master) and the memory (slave).
//   MemReq, RdWrBar, Address, DataIn, ByteEn : master -> slave request
//   DataOut, MemRdy, MemErr, Busy            : slave -> master response
interface wait_state_mem_if #(
  parameter int AddrWidth = 24,
  parameter int DataWidth = 32
);
  logic                     MemReq;
  logic                     RdWrBar;
  logic [AddrWidth-1:0]     Address;
  logic [DataWidth-1:0]     DataIn;
  logic [DataWidth/8-1:0]   ByteEn;
  logic [DataWidth-1:0]     DataOut;
  logic                     MemRdy;
  logic                     MemErr;
  logic                     Busy;

  modport master (
    output MemReq, RdWrBar, Address, DataIn, ByteEn,
    input  DataOut, MemRdy, MemErr, Busy
  );

  modport slave (
    input  MemReq, RdWrBar, Address, DataIn, ByteEn,
    output DataOut, MemRdy, MemErr, Busy
  );
endinterface

// File: rtl/wait_state_mem_array.sv
// wait_state_mem_array
//   Single-port Words x DataWidth storage. Synchronous byte-lane write,
//   synchronous registered read. Storage is never reset.
//   clock : clock
//   en    : access enable for this cycle
//   we    : 1 = write, 0 = read (only while en)
//   be    : byte-lane write enables
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, updated only on read accesses
module wait_state_mem_array
  import wait_state_mem_pkg::*;
#(
  parameter int Words     = 4096,
  parameter int DataWidth = 32
) (
  input  logic                             clock,
  input  logic                             en,
  input  logic                             we,
  input  logic [byte_lanes(DataWidth)-1:0] be,
  input  logic [clog2(Words)-1:0]          idx,
  input  logic [DataWidth-1:0]             wdata,
  output logic [DataWidth-1:0]             rdata
);

  localparam int LANES = byte_lanes(DataWidth);

  logic [DataWidth-1:0] mem [Words];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/wait_state_mem.sv
// wait_state_mem
//   Request/ready memory slave with programmable wait states, byte-lane
//   writes and out-of-range error reporting.
//   clock    : clock, all state on rising edge
//   ResetBar : asynchronous active-low reset
//   bus      : slave side of wait_state_mem_if
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for MemReq; also the MemRdy cycle (Busy still high)
//   ST_WAIT   | counting down WaitStates cycles
//   ST_ACCESS | array enabled; write commits / read data registered
//   ST_DONE   | registers DataOut, pulses MemRdy/MemErr on exit
module wait_state_mem
  import wait_state_mem_pkg::*;
#(
  parameter int Words      = 4096,
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 24,
  parameter int WaitStates = 2
) (
  input  logic            clock,
  input  logic            ResetBar,
  wait_state_mem_if.slave bus
);

  localparam int IDX_W = clog2(Words);
  localparam int LANES = byte_lanes(DataWidth);
  // One extra bit so Words == 2**AddrWidth is still representable.
  localparam logic [AddrWidth:0]        WORDS_LIMIT = (AddrWidth+1)'(Words);
  localparam logic [WAIT_CNT_W-1:0]     WAIT_INIT   = WAIT_CNT_W'(WaitStates);
  localparam logic [WAIT_CNT_W-1:0]     WAIT_ONE    = WAIT_CNT_W'(1);

  state_e                  state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    req_rd;
  logic                    req_err;
  logic [IDX_W-1:0]        req_idx;
  logic [DataWidth-1:0]    req_data;
  logic [LANES-1:0]        req_be;
  logic [DataWidth-1:0]    arr_rdata;
  logic                    arr_en;

  // Out-of-range requests never touch the array, so upper address bits
  // cannot alias onto a valid location.
  assign arr_en = (state == ST_ACCESS) && !req_err;

  wait_state_mem_array #(
    .Words     (Words),
    .DataWidth (DataWidth)
  ) u_array (
    .clock (clock),
    .en    (arr_en),
    .we    (!req_rd),
    .be    (req_be),
    .idx   (req_idx),
    .wdata (req_data),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clock or negedge ResetBar) begin
    if (!ResetBar) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      req_rd      <= 1'b0;
      req_err     <= 1'b0;
      req_idx     <= '0;
      req_data    <= '0;
      req_be      <= '0;
      bus.DataOut <= '0;
      bus.MemRdy  <= 1'b0;
      bus.MemErr  <= 1'b0;
      bus.Busy    <= 1'b0;
    end else begin
      bus.MemRdy <= 1'b0;
      bus.MemErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Busy is only high in IDLE during the MemRdy cycle; drop it here
          // so a held MemReq is taken on the following edge.
          if (bus.Busy) begin
            bus.Busy <= 1'b0;
          end else if (bus.MemReq) begin
            req_rd   <= bus.RdWrBar;
            req_err  <= ({1'b0, bus.Address} >= WORDS_LIMIT);
            req_idx  <= bus.Address[IDX_W-1:0];
            req_data <= bus.DataIn;
            req_be   <= bus.ByteEn;
            bus.Busy <= 1'b1;
            if (WaitStates > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_ONE) state <= ST_ACCESS;
          wait_cnt <= wait_cnt - WAIT_ONE;
        end
        ST_ACCESS: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          bus.MemRdy <= 1'b1;
          bus.MemErr <= req_err;
          if (req_rd) bus.DataOut <= req_err ? '0 : arr_rdata;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
